// File: rtl/reg_deserializer_pkg.sv
// Shared definitions for the universal shift register and its serial receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_deserializer_pkg;

    // Shift register operating modes; the receiver consumes the PUSH stream.
    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_PUSH  = 2'd1,
        MODE_CYCLE = 2'd2
    } shift_mode_t;

    // Receiver frame states.
    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    // Bit order of a serial frame.
    localparam logic DIR_MSBF = 1'b0;
    localparam logic DIR_LSBF = 1'b1;

endpackage

// File: rtl/reg_deserializer_rx_hold_buf.sv
// 1-entry holding register for assembled words, with sticky overflow and accepted-word count.
// Latency: a completed word is visible on VALID/DOUT right after the edge that presents it.
// Backpressure: a word arriving while the entry is full and RDY=0 is dropped and OVF is set.
module reg_deserializer_rx_hold_buf #(
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            RST_L,
    input  logic            wr_vld,
    input  logic [W-1:0]    wr_dat,
    input  logic            RDY,
    output logic [W-1:0]    DOUT,
    output logic            VALID,
    output logic            OVF,
    output logic [CNTW-1:0] WCNT
);

    logic xfer;

    // A transfer frees the entry on the same edge, so a new word may refill it.
    assign xfer = VALID && RDY;

    // Load, drain and overflow tracking for the single entry.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            DOUT  <= '0;
            VALID <= 1'b0;
            OVF   <= 1'b0;
            WCNT  <= '0;
        end else begin
            if (wr_vld) begin
                if (!VALID || xfer) begin
                    DOUT  <= wr_dat;
                    VALID <= 1'b1;
                    WCNT  <= WCNT + CNTW'(1);
                end else begin
                    OVF   <= 1'b1;
                end
            end else if (xfer) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_deserializer.sv
// Serial receiver: rebuilds N-bit words from the shift register's PUSH-mode S_OUT stream.
// Latency: word visible on DOUT/VALID right after the edge sampling its Nth bit.
// Backpressure: 1-entry buffer; words completing while it is full and RDY=0 are dropped (OVF).
module reg_deserializer
    import reg_deserializer_pkg::*;
#(
    parameter int N    = 4,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            RST_L,
    input  logic            ENB,
    input  logic            S_IN,
    input  logic            STRB,
    input  logic            DIR,
    input  logic            RDY,
    output logic [N-1:0]    DOUT,
    output logic            VALID,
    output logic            OVF,
    output logic            FRM_ERR,
    output logic [CNTW-1:0] WCNT
);

    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] LAST = BW'(N - 1);

    rx_state_t    state;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  acc;
    logic          dir_q;
    logic          word_vld;
    logic [N-1:0]  word_dat;

    // Shift one bit into the accumulator in the frame's bit order.
    function automatic logic [N-1:0] shift_in(input logic [N-1:0] a,
                                              input logic b,
                                              input logic d);
        if (d == DIR_LSBF) return {b, a[N-1:1]};
        else               return {a[N-2:0], b};
    endfunction

    // The Nth sample completes the frame; a coincident STRB is not a restart.
    assign word_vld = ENB && (state == RX_RECV) && (bit_cnt == LAST);
    assign word_dat = shift_in(acc, S_IN, dir_q);

    // Frame FSM, bit counter and accumulator; everything holds while ENB=0.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            acc     <= '0;
            dir_q   <= DIR_MSBF;
            FRM_ERR <= 1'b0;
        end else begin
            FRM_ERR <= 1'b0;
            if (ENB) begin
                case (state)
                    RX_IDLE: begin
                        if (STRB) begin
                            dir_q   <= DIR;
                            acc     <= shift_in('0, S_IN, DIR);
                            bit_cnt <= BW'(1);
                            state   <= RX_RECV;
                        end
                    end
                    RX_RECV: begin
                        if (word_vld) begin
                            acc     <= word_dat;
                            bit_cnt <= '0;
                            state   <= RX_IDLE;
                        end else if (STRB) begin
                            FRM_ERR <= 1'b1;
                            dir_q   <= DIR;
                            acc     <= shift_in('0, S_IN, DIR);
                            bit_cnt <= BW'(1);
                        end else begin
                            acc     <= word_dat;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    reg_deserializer_rx_hold_buf #(
        .W    (N),
        .CNTW (CNTW)
    ) u_hold (
        .CLK    (CLK),
        .RST_L  (RST_L),
        .wr_vld (word_vld),
        .wr_dat (word_dat),
        .RDY    (RDY),
        .DOUT   (DOUT),
        .VALID  (VALID),
        .OVF    (OVF),
        .WCNT   (WCNT)
    );

endmodule

// File: tb/tb_reg_deserializer.sv
module tb_reg_deserializer;

    localparam int N    = 4;
    localparam int CNTW = 8;

    logic            CLK = 1'b0;
    logic            RST_L;
    logic            ENB;
    logic            S_IN;
    logic            STRB;
    logic            DIR;
    logic            RDY;
    logic [N-1:0]    DOUT;
    logic            VALID;
    logic            OVF;
    logic            FRM_ERR;
    logic [CNTW-1:0] WCNT;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bits collected since the frame's strobe.
    bit              m_busy;
    bit              m_dir;
    bit              m_q[$];
    logic [N-1:0]    m_dout;
    bit              m_valid;
    bit              m_ovf;
    bit              m_frm;
    logic [CNTW-1:0] m_wcnt;

    reg_deserializer #(.N(N), .CNTW(CNTW)) dut (
        .CLK     (CLK),
        .RST_L   (RST_L),
        .ENB     (ENB),
        .S_IN    (S_IN),
        .STRB    (STRB),
        .DIR     (DIR),
        .RDY     (RDY),
        .DOUT    (DOUT),
        .VALID   (VALID),
        .OVF     (OVF),
        .FRM_ERR (FRM_ERR),
        .WCNT    (WCNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] assemble();
        logic [N-1:0] w = '0;
        for (int i = 0; i < N; i++) begin
            if (m_dir) w[i] = m_q[i];
            else       w[N-1-i] = m_q[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dir = 0; m_q.delete();
        m_dout = '0; m_valid = 0; m_ovf = 0; m_frm = 0; m_wcnt = '0;
    endtask

    // Apply the receive and handshake rules for one rising edge.
    task automatic model_edge(input bit enb, input bit s_in, input bit strb,
                              input bit dir, input bit rdy);
        bit done = 0;
        bit xfer;
        logic [N-1:0] w = '0;
        m_frm = 0;
        if (enb) begin
            if (!m_busy) begin
                if (strb) begin
                    m_busy = 1; m_dir = dir; m_q.delete(); m_q.push_back(s_in);
                end
            end else if (strb && (m_q.size() + 1 < N)) begin
                m_frm = 1; m_dir = dir; m_q.delete(); m_q.push_back(s_in);
            end else begin
                m_q.push_back(s_in);
                if (m_q.size() == N) begin
                    done = 1; w = assemble(); m_busy = 0; m_q.delete();
                end
            end
        end
        xfer = m_valid && rdy;
        if (done) begin
            if (!m_valid || xfer) begin
                m_dout = w; m_valid = 1; m_wcnt = m_wcnt + 1'b1;
            end else begin
                m_ovf = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        check("dout",    32'(DOUT),    32'(m_dout));
        check("valid",   32'(VALID),   32'(m_valid));
        check("ovf",     32'(OVF),     32'(m_ovf));
        check("frm_err", 32'(FRM_ERR), 32'(m_frm));
        check("wcnt",    32'(WCNT),    32'(m_wcnt));
    endtask

    task automatic step(input bit enb, input bit s_in, input bit strb,
                        input bit dir, input bit rdy);
        ENB = enb; S_IN = s_in; STRB = strb; DIR = dir; RDY = rdy;
        @(posedge CLK);
        model_edge(enb, s_in, strb, dir, rdy);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit dir, input bit rdy);
        for (int i = 0; i < N; i++) begin
            step(1'b1, dir ? w[i] : w[N-1-i], i == 0, dir, rdy);
        end
    endtask

    task automatic apply_reset();
        ENB = 0; STRB = 0; S_IN = 0; DIR = 0; RDY = 0;
        RST_L = 1'b0;
        #1;
        check("rst_dout",  32'(DOUT),    0);
        check("rst_valid", 32'(VALID),   0);
        check("rst_ovf",   32'(OVF),     0);
        check("rst_frm",   32'(FRM_ERR), 0);
        check("rst_wcnt",  32'(WCNT),    0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST_L = 1'b1;
    endtask

    initial begin
        RST_L = 1'b1;
        ENB = 0; S_IN = 0; STRB = 0; DIR = 0; RDY = 0;
        #2;
        apply_reset();

        // MSB-first word, drained the following cycle.
        send_word(4'hD, 1'b0, 1'b1);
        check("msbf_dout", 32'(DOUT), 32'hD);
        check("msbf_wcnt", 32'(WCNT), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("msbf_drain", 32'(VALID), 0);

        // LSB-first word.
        send_word(4'hA, 1'b1, 1'b1);
        check("lsbf_dout", 32'(DOUT), 32'hA);
        check("lsbf_wcnt", 32'(WCNT), 2);

        // Overflow with RDY held low, then drain.
        apply_reset();
        send_word(4'h6, 1'b0, 1'b0);
        send_word(4'h9, 1'b0, 1'b0);
        check("ovf_dout", 32'(DOUT), 32'h6);
        check("ovf_flag", 32'(OVF),  1);
        check("ovf_wcnt", 32'(WCNT), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_drain", 32'(VALID), 0);
        check("ovf_sticky", 32'(OVF), 1);

        // Restart: two bits, then a fresh strobe carrying 1,1,0,1.
        apply_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("restart_pulse", 32'(FRM_ERR), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("restart_once", 32'(FRM_ERR), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("restart_dout", 32'(DOUT), 32'hD);

        // ENB gating mid-frame; STRB and S_IN must be ignored while frozen.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'(i), 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("gate_dout", 32'(DOUT), 32'hD);

        // STRB on the Nth bit completes the word rather than restarting.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("strb_last_dout", 32'(DOUT), 32'h5);
        check("strb_last_frm",  32'(FRM_ERR), 0);

        // Reset mid-frame discards the partial word.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_reset();
        send_word(4'h3, 1'b0, 1'b1);
        check("rst_frame_dout", 32'(DOUT), 32'h3);
        check("rst_frame_wcnt", 32'(WCNT), 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
        end

        // Counter wrap after 256 accepted words.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            send_word(N'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        check("wrap_wcnt", 32'(WCNT), 0);
        check("wrap_ovf",  32'(OVF),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
